conf_cal_ctrl: RTL

CONF_CAL_CTRL -- requirements
Module: conf_cal_ctrl

---
 rtl/conf_cal_pkg.sv | 23 ++
 rtl/conf_therm_enc.sv | 19 +
 rtl/conf_cal_ctrl.sv | 183 ++++++++++++++++++
 3 files changed

// File: rtl/conf_cal_pkg.sv
// Shared types and constants for the inverter-chain calibration controller.
// Holds the FSM state encoding, feedback decode values and parameter defaults.
package conf_cal_pkg;

    localparam int DEF_CONF_BITS     = 16;
    localparam int DEF_SETTLE_CYCLES = 8;
    localparam int DEF_LOCK_COUNT    = 4;
    localparam int DEF_MAX_STEPS     = 40;

    // Sampled {O_INVU, O_INVD}; the other two codes count as balanced.
    localparam logic [1:0] UP_DOM = 2'b10;
    localparam logic [1:0] DN_DOM = 2'b01;

    typedef enum logic [2:0] {
        S_IDLE,
        S_SETTLE,
        S_SAMPLE,
        S_ADJUST,
        S_LOCK,
        S_FAIL
    } cal_state_e;

endpackage

// File: rtl/conf_therm_enc.sv
// Index to thermometer-code conversion: the low idx_i bits of nconf_o are set,
// pconf_o is the bitwise complement.
module conf_therm_enc #(
    parameter int CONF_BITS = 16,
    parameter int IDX_W     = $clog2(CONF_BITS + 1)
) (
    input  logic [IDX_W-1:0]     idx_i,
    output logic [CONF_BITS-1:0] nconf_o,
    output logic [CONF_BITS-1:0] pconf_o
);

    always_comb begin
        for (int i = 0; i < CONF_BITS; i++) begin
            nconf_o[i] = (i < int'(idx_i));
        end
        pconf_o = ~nconf_o;
    end

endmodule

// File: rtl/conf_cal_ctrl.sv
// Inverter-chain calibration controller: nudges the up/down indices until the
// sampled feedback stays balanced. Define CONF_CAL_SYNC_EN to double-flop the feedback inputs.
module conf_cal_ctrl
    import conf_cal_pkg::*;
#(
    parameter int CONF_BITS     = DEF_CONF_BITS,
    parameter int SETTLE_CYCLES = DEF_SETTLE_CYCLES,
    parameter int LOCK_COUNT    = DEF_LOCK_COUNT,
    parameter int MAX_STEPS     = DEF_MAX_STEPS
) (
    input  logic                 CLK,
    input  logic                 RST,
    input  logic                 START,
    input  logic                 O_INVU,
    input  logic                 O_INVD,
    output logic [CONF_BITS-1:0] INVU_NCONF,
    output logic [CONF_BITS-1:0] INVU_PCONF,
    output logic [CONF_BITS-1:0] INVD_NCONF,
    output logic [CONF_BITS-1:0] INVD_PCONF,
    output logic                 BUSY,
    output logic                 LOCKED,
    output logic                 FAIL
);

    localparam int IDX_W   = $clog2(CONF_BITS + 1);
    localparam int SET_W   = $clog2(SETTLE_CYCLES + 1);
    localparam int MATCH_W = $clog2(LOCK_COUNT + 1);
    localparam int STEP_W  = $clog2(MAX_STEPS + 1);

    localparam logic [IDX_W-1:0]     IDX_ONE    = IDX_W'(1);
    localparam logic [IDX_W-1:0]     IDX_MAX    = IDX_W'(CONF_BITS);
    localparam logic [IDX_W-1:0]     IDX_MID    = IDX_W'(CONF_BITS / 2);
    localparam logic [SET_W-1:0]     SET_ONE    = SET_W'(1);
    localparam logic [SET_W-1:0]     SET_LAST   = SET_W'(SETTLE_CYCLES - 1);
    localparam logic [MATCH_W-1:0]   MATCH_ONE  = MATCH_W'(1);
    localparam logic [MATCH_W-1:0]   MATCH_LOCK = MATCH_W'(LOCK_COUNT);
    localparam logic [STEP_W-1:0]    STEP_ONE   = STEP_W'(1);
    localparam logic [STEP_W-1:0]    STEP_MAX   = STEP_W'(MAX_STEPS);
    localparam logic [CONF_BITS-1:0] MID_NCONF  = {CONF_BITS{1'b1}} >> (CONF_BITS - CONF_BITS / 2);

    cal_state_e           state_q, state_d;
    logic [IDX_W-1:0]     u_idx_q, u_idx_d, d_idx_q, d_idx_d;
    logic [SET_W-1:0]     settle_q, settle_d;
    logic [MATCH_W-1:0]   match_q, match_d;
    logic [STEP_W-1:0]    step_q, step_d;
    logic [1:0]           sample_q, sample_d;
    logic [1:0]           fb;
    logic [CONF_BITS-1:0] invu_n_d, invu_p_d, invd_n_d, invd_p_d;
    logic [CONF_BITS-1:0] invu_n_q, invu_p_q, invd_n_q, invd_p_q;
    logic                 busy_q, locked_q, fail_q;

`ifdef CONF_CAL_SYNC_EN
    logic [1:0] fb_meta_q, fb_sync_q;

    always_ff @(posedge CLK) begin
        if (RST) begin
            fb_meta_q <= 2'b00;
            fb_sync_q <= 2'b00;
        end else begin
            fb_meta_q <= {O_INVU, O_INVD};
            fb_sync_q <= fb_meta_q;
        end
    end

    assign fb = fb_sync_q;
`else
    assign fb = {O_INVU, O_INVD};
`endif

    always_comb begin
        // NOTE: every combinational output gets a default first so no path can infer a latch.
        state_d  = state_q;
        u_idx_d  = u_idx_q;
        d_idx_d  = d_idx_q;
        settle_d = '0;
        match_d  = match_q;
        step_d   = step_q;
        sample_d = sample_q;
        unique case (state_q)
            S_IDLE, S_LOCK, S_FAIL: begin
                if (START) begin
                    state_d = S_SETTLE;
                    match_d = '0;
                    step_d  = '0;
                end
            end
            S_SETTLE: begin
                if (settle_q == SET_LAST) state_d = S_SAMPLE;
                else                      settle_d = settle_q + SET_ONE;
            end
            S_SAMPLE: begin
                sample_d = fb;
                state_d  = S_ADJUST;
            end
            S_ADJUST: begin
                if (sample_q == UP_DOM || sample_q == DN_DOM) begin
                    // Falls through to FAIL when out of steps or both indices are pinned.
                    state_d = S_FAIL;
                    if (step_q < STEP_MAX) begin
                        if (sample_q == UP_DOM && u_idx_q != '0) begin
                            u_idx_d = u_idx_q - IDX_ONE;
                            state_d = S_SETTLE;
                        end else if (sample_q == UP_DOM && d_idx_q != IDX_MAX) begin
                            d_idx_d = d_idx_q + IDX_ONE;
                            state_d = S_SETTLE;
                        end else if (sample_q == DN_DOM && d_idx_q != '0) begin
                            d_idx_d = d_idx_q - IDX_ONE;
                            state_d = S_SETTLE;
                        end else if (sample_q == DN_DOM && u_idx_q != IDX_MAX) begin
                            u_idx_d = u_idx_q + IDX_ONE;
                            state_d = S_SETTLE;
                        end
                    end
                    if (state_d == S_SETTLE) begin
                        match_d = '0;
                        step_d  = step_q + STEP_ONE;
                    end
                end else begin
                    match_d = match_q + MATCH_ONE;
                    state_d = (match_d == MATCH_LOCK) ? S_LOCK : S_SETTLE;
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    // Outputs are registered from next-state values so they track the FSM with no extra lag.
    conf_therm_enc #(.CONF_BITS(CONF_BITS), .IDX_W(IDX_W)) u_enc_up (
        .idx_i   (u_idx_d),
        .nconf_o (invu_n_d),
        .pconf_o (invu_p_d)
    );

    conf_therm_enc #(.CONF_BITS(CONF_BITS), .IDX_W(IDX_W)) u_enc_dn (
        .idx_i   (d_idx_d),
        .nconf_o (invd_n_d),
        .pconf_o (invd_p_d)
    );

    always_ff @(posedge CLK) begin
        // NOTE: state registers use non-blocking assignments so all flops update from pre-edge values.
        if (RST) begin
            state_q  <= S_IDLE;
            u_idx_q  <= IDX_MID;
            d_idx_q  <= IDX_MID;
            settle_q <= '0;
            match_q  <= '0;
            step_q   <= '0;
            sample_q <= 2'b00;
            invu_n_q <= MID_NCONF;
            invu_p_q <= ~MID_NCONF;
            invd_n_q <= MID_NCONF;
            invd_p_q <= ~MID_NCONF;
            busy_q   <= 1'b0;
            locked_q <= 1'b0;
            fail_q   <= 1'b0;
        end else begin
            state_q  <= state_d;
            u_idx_q  <= u_idx_d;
            d_idx_q  <= d_idx_d;
            settle_q <= settle_d;
            match_q  <= match_d;
            step_q   <= step_d;
            sample_q <= sample_d;
            invu_n_q <= invu_n_d;
            invu_p_q <= invu_p_d;
            invd_n_q <= invd_n_d;
            invd_p_q <= invd_p_d;
            busy_q   <= (state_d == S_SETTLE) || (state_d == S_SAMPLE) || (state_d == S_ADJUST);
            locked_q <= (state_d == S_LOCK);
            fail_q   <= (state_d == S_FAIL);
        end
    end

    assign INVU_NCONF = invu_n_q;
    assign INVU_PCONF = invu_p_q;
    assign INVD_NCONF = invd_n_q;
    assign INVD_PCONF = invd_p_q;
    assign BUSY       = busy_q;
    assign LOCKED     = locked_q;
    assign FAIL       = fail_q;

endmodule
